add_sub_rs: RTL

ADD_SUB_RS -- requirements
Module: add_sub_rs

---
 rtl/add_sub_rs.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/add_sub_rs.sv
// Reservation station for the add/sub execution unit.
// Holds up to DEPTH dispatched operations, snoops the CDB for pending
// operands (op1, op2 and carry), and feeds a single-entry issue register.

package add_sub_pkg;
    typedef struct packed {
        logic subtract;
        logic add_CA;
        logic set_CA;
    } add_sub_decode_t;
endpackage

module add_sub_rs
    import add_sub_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int DEPTH       = 4,
    parameter int RS_OFFSET   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    // dispatch side
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic                   dispatch_op1_valid,
    input  logic [31:0]            dispatch_op1_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag,
    input  logic                   dispatch_op2_valid,
    input  logic [31:0]            dispatch_op2_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag,
    input  logic                   dispatch_ca_valid,
    input  logic                   dispatch_ca_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_ca_tag,
    input  add_sub_decode_t        dispatch_control,
    input  logic [4:0]             dispatch_result_reg_addr,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    // common data bus
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    input  logic                   cdb_ca,
    // issue side
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [4:0]             issue_result_reg_addr,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output logic                   issue_carry,
    output add_sub_decode_t        issue_control
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // station entries
    logic [DEPTH-1:0]       busy;
    logic [DEPTH-1:0]       op1_val;
    logic [DEPTH-1:0]       op2_val;
    logic [DEPTH-1:0]       ca_val;
    logic [DEPTH-1:0]       ca_data;
    logic [31:0]            op1_data [DEPTH];
    logic [31:0]            op2_data [DEPTH];
    logic [RS_ID_WIDTH-1:0] op1_tag  [DEPTH];
    logic [RS_ID_WIDTH-1:0] op2_tag  [DEPTH];
    logic [RS_ID_WIDTH-1:0] ca_tag   [DEPTH];
    add_sub_decode_t        ctrl     [DEPTH];
    logic [4:0]             rd       [DEPTH];

    // issue register
    logic                   iss_valid_p1;
    logic [RS_ID_WIDTH-1:0] iss_rs_id_p1;
    logic [4:0]             iss_rd_p1;
    logic [31:0]            iss_op1_p1;
    logic [31:0]            iss_op2_p1;
    logic                   iss_carry_p1;
    add_sub_decode_t        iss_ctrl_p1;

    logic [DEPTH-1:0] elig;
    logic [IDX_W-1:0] free_idx;
    logic             free_any;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             issue_en;
    logic             load_issue;
    logic             dispatch_fire;
    logic             fwd_op1;
    logic             fwd_op2;
    logic             fwd_ca;

    // Lowest free entry and lowest eligible entry, both from registered state
    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        sel_idx  = '0;
        sel_any  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = busy[i] & op1_val[i] & op2_val[i] & (ca_val[i] | ~ctrl[i].add_CA);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
                free_any = 1'b1;
            end
            if (elig[i]) begin
                sel_idx = IDX_W'(i);
                sel_any = 1'b1;
            end
        end
    end

    assign dispatch_ready = free_any;
    assign dispatch_rs_id = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(free_idx);
    assign dispatch_fire  = dispatch_valid & free_any;
    assign issue_en       = ~iss_valid_p1 | issue_ready;
    assign load_issue     = issue_en & sel_any;

    // A pending operand whose producer broadcasts in the dispatch cycle is captured directly
    assign fwd_op1 = ~dispatch_op1_valid & cdb_valid & (cdb_rs_id == dispatch_op1_tag);
    assign fwd_op2 = ~dispatch_op2_valid & cdb_valid & (cdb_rs_id == dispatch_op2_tag);
    assign fwd_ca  = ~dispatch_ca_valid  & cdb_valid & (cdb_rs_id == dispatch_ca_tag);

    // Entry state: CDB snoop, free on issue load, allocate on dispatch
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && cdb_valid) begin
                    if (!op1_val[i] && op1_tag[i] == cdb_rs_id) begin
                        op1_val[i]  <= 1'b1;
                        op1_data[i] <= cdb_result;
                    end
                    if (!op2_val[i] && op2_tag[i] == cdb_rs_id) begin
                        op2_val[i]  <= 1'b1;
                        op2_data[i] <= cdb_result;
                    end
                    if (!ca_val[i] && ca_tag[i] == cdb_rs_id) begin
                        ca_val[i]  <= 1'b1;
                        ca_data[i] <= cdb_ca;
                    end
                end
            end
            if (load_issue) begin
                busy[sel_idx] <= 1'b0;
            end
            // free_idx is never the entry being loaded: that one is still busy
            if (dispatch_fire) begin
                busy[free_idx]     <= 1'b1;
                op1_val[free_idx]  <= dispatch_op1_valid | fwd_op1;
                op1_data[free_idx] <= dispatch_op1_valid ? dispatch_op1_value : cdb_result;
                op1_tag[free_idx]  <= dispatch_op1_tag;
                op2_val[free_idx]  <= dispatch_op2_valid | fwd_op2;
                op2_data[free_idx] <= dispatch_op2_valid ? dispatch_op2_value : cdb_result;
                op2_tag[free_idx]  <= dispatch_op2_tag;
                ca_val[free_idx]   <= dispatch_ca_valid | fwd_ca;
                ca_data[free_idx]  <= dispatch_ca_valid ? dispatch_ca_value : cdb_ca;
                ca_tag[free_idx]   <= dispatch_ca_tag;
                ctrl[free_idx]     <= dispatch_control;
                rd[free_idx]       <= dispatch_result_reg_addr;
            end
        end
    end

    // Issue register: refills when empty or handshaking, holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_p1 <= 1'b0;
            iss_rs_id_p1 <= '0;
            iss_rd_p1    <= '0;
            iss_op1_p1   <= '0;
            iss_op2_p1   <= '0;
            iss_carry_p1 <= 1'b0;
            iss_ctrl_p1  <= '0;
        end else if (issue_en) begin
            iss_valid_p1 <= sel_any;
            if (sel_any) begin
                iss_rs_id_p1 <= RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel_idx);
                iss_rd_p1    <= rd[sel_idx];
                iss_op1_p1   <= op1_data[sel_idx];
                iss_op2_p1   <= op2_data[sel_idx];
                iss_carry_p1 <= ctrl[sel_idx].add_CA ? ca_data[sel_idx] : 1'b0;
                iss_ctrl_p1  <= ctrl[sel_idx];
            end
        end
    end

    assign issue_valid           = iss_valid_p1;
    assign issue_rs_id           = iss_rs_id_p1;
    assign issue_result_reg_addr = iss_rd_p1;
    assign issue_op1             = iss_op1_p1;
    assign issue_op2             = iss_op2_p1;
    assign issue_carry           = iss_carry_p1;
    assign issue_control         = iss_ctrl_p1;

endmodule
